// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - debounced STEP/RUN front panel driving one-cycle advance pulses
// Optional STEP_SEQUENCER_COUNT_EN builds the 16-bit issued-step counter.
module step_sequencer #(
  parameter logic [15:0] debounce_cycles_p = 16'd10000,
  parameter logic [23:0] run_period_p      = 24'd1000000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        step_btn_i,
  input  logic        run_btn_i,
  input  logic        busy_i,
  output logic        step_o,
  output logic        running_o,
  output logic [15:0] step_count_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Bit 0 is the STEP path, bit 1 the RUN path.
  logic [1:0]  sync1_q, sync2_q, acc_q, acc_prev_q;
  logic [15:0] db_cnt_q [2];
  logic [1:0]  press;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {run_btn_i, step_btn_i};
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == debounce_cycles_p - 16'd1) begin
          acc_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign press = acc_q & ~acc_prev_q;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic        pending_q, pending_d;
  logic        step_q, step_d;
  logic        running_q, running_d;
  logic        req, issue;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        req = press[0];
        if (press[1]) begin
          state_d = RUN;
          timer_d = '0;
        end
      end
      RUN: begin
        req = (timer_q == run_period_p - 24'd1);
        timer_d = req ? 24'd0 : timer_q + 24'd1;
        if (press[1]) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // The step_q term keeps pulses from ever landing on adjacent cycles.
    issue     = pending_q & ~busy_i & ~step_q;
    pending_d = req | (pending_q & ~issue);
    step_d    = issue;
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  assign step_o    = step_q;
  assign running_o = running_q;

`ifdef STEP_SEQUENCER_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) count_q <= '0;
    else if (step_d) count_q <= count_q + 16'd1;
  end

  assign step_count_o = count_q;
`else
  assign step_count_o = 16'd0;
`endif

endmodule
